// File: rtl/image_loader.sv
// image_loader: assembles a streamed image into a flat register bank and hands it to the CNN core
module image_loader #(
  parameter int IMG_SIZE = 64,
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_W-1:0]          s_data,
  input  logic                       s_last,
  output logic [IMG_SIZE*DATA_W-1:0] img_flat,
  output logic                       cnn_enable,
  input  logic                       cnn_done,
  output logic                       frame_err,
  output logic                       busy,
  output logic [CNT_W-1:0]           frames_done
);
  localparam int IDX_W = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMG_SIZE - 1);

  typedef enum logic [1:0] {LOAD, FIRE, WAIT} state_t;

  state_t                          r_state, w_next;
  logic [IDX_W-1:0]                r_wr_idx, w_next_idx;
  logic                            r_drop, w_next_drop;
  logic                            w_err, w_wr, w_done, w_acc, w_at_end;
  logic [IMG_SIZE-1:0][DATA_W-1:0] r_img;
  logic                            r_enable, r_err, r_busy;
  logic [CNT_W-1:0]                r_frames;

  assign s_ready     = (r_state == LOAD);
  assign w_acc       = s_valid && s_ready;
  assign w_at_end    = (r_wr_idx == LAST_IDX);
  assign img_flat    = r_img;
  assign cnn_enable  = r_enable;
  assign frame_err   = r_err;
  assign busy        = r_busy;
  assign frames_done = r_frames;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LOAD;
    else        r_state <= w_next;
  end

  // next state, write index, drop mode and event strobes
  always_comb begin
    w_next      = r_state;
    w_next_idx  = r_wr_idx;
    w_next_drop = r_drop;
    w_err       = 1'b0;
    w_wr        = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      LOAD: if (w_acc) begin
        if (r_drop) begin
          w_next_drop = !s_last;
        end else begin
          w_wr       = 1'b1;
          w_next_idx = r_wr_idx + 1'b1;
          if (w_at_end || s_last) begin
            w_next_idx  = '0;
            w_next      = (w_at_end && s_last) ? FIRE : LOAD;
            w_err       = !(w_at_end && s_last);
            w_next_drop = w_at_end && !s_last;
          end
        end
      end
      FIRE: w_next = WAIT;
      WAIT: if (cnn_done) begin
        w_next = LOAD;
        w_done = 1'b1;
      end
      default: w_next = LOAD;
    endcase
  end

  // datapath: image words, index, drop flag, registered outputs and frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_idx <= '0;
      r_drop   <= 1'b0;
      r_img    <= '0;
      r_enable <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_frames <= '0;
    end else begin
      r_wr_idx <= w_next_idx;
      r_drop   <= w_next_drop;
      if (w_wr) r_img[r_wr_idx] <= s_data;
      r_enable <= (w_next == FIRE);
      r_err    <= w_err;
      r_busy   <= (w_next != LOAD);
      r_frames <= r_frames + CNT_W'(w_done);
    end
  end
endmodule

// File: tb/tb_image_loader.sv
// tb_image_loader: randomized and directed checks of image_loader against a frame-level reference model
module tb_image_loader;
  localparam int IMG = 64;
  localparam int DW  = 32;
  localparam int CW  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DW-1:0]     s_data = '0;
  logic              s_last = 1'b0;
  logic [IMG*DW-1:0] img_flat;
  logic              cnn_enable;
  logic              cnn_done = 1'b0;
  logic              frame_err;
  logic              busy;
  logic [CW-1:0]     frames_done;

  image_loader #(.IMG_SIZE(IMG), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .img_flat(img_flat), .cnn_enable(cnn_enable), .cnn_done(cnn_done),
    .frame_err(frame_err), .busy(busy), .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int en_cnt = 0;
  int err_cnt = 0;
  int acc_cnt = 0;
  int gap_max = 0;
  logic [DW-1:0] sent [IMG];

  // reference model: 0 = receiving, 1 = start pulse, 2 = core running
  int                     m_phase;
  int                     m_pos;
  bit                     m_drop;
  bit                     m_err;
  logic [CW-1:0]          m_cnt;
  logic [IMG-1:0][DW-1:0] m_img;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_pos = 0; m_drop = 0; m_err = 0; m_cnt = '0; m_img = '0;
  endtask

  // predict the state after the next rising edge from the inputs that edge will sample
  task automatic model_step();
    m_err = 0;
    if (m_phase == 0) begin
      if (s_valid) begin
        if (m_drop) begin
          if (s_last) m_drop = 0;
        end else begin
          m_img[m_pos] = s_data;
          m_pos++;
          if (s_last) begin
            if (m_pos == IMG) m_phase = 1;
            else m_err = 1;
            m_pos = 0;
          end else if (m_pos == IMG) begin
            m_err = 1; m_drop = 1; m_pos = 0;
          end
        end
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (cnn_done) begin
      m_phase = 0;
      m_cnt++;
    end
  endtask

  // compare process: outputs are stable at the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      chk("s_ready", s_ready, m_phase == 0);
      chk("cnn_enable", cnn_enable, m_phase == 1);
      chk("busy", busy, m_phase != 0);
      chk("frame_err", frame_err, m_err);
      chk("frames_done", frames_done, m_cnt);
      n_cmp++;
      if (img_flat !== m_img) begin
        int bad;
        bad = 0;
        for (int i = IMG - 1; i >= 0; i--) if (img_flat[i*DW +: DW] !== m_img[i]) bad = i;
        n_bad++;
        $display("FAIL img_flat word %0d: got %h expected %h at %0t", bad, img_flat[bad*DW +: DW], m_img[bad], $time);
      end
      if (cnn_enable) en_cnt++;
      if (frame_err) err_cnt++;
      if (rst_n && s_valid && s_ready) acc_cnt++;
      if (rst_n) model_step();
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic beat(input logic [DW-1:0] d, input bit l);
    int budget;
    bit rdy;
    repeat ($urandom_range(0, gap_max)) begin
      s_valid = 0; s_data = $urandom; s_last = $urandom;
      tick();
    end
    s_valid = 1; s_data = d; s_last = l;
    budget = 300;
    forever begin
      rdy = s_ready;
      tick();
      if (rdy) break;
      if (--budget == 0) begin
        chk("handshake_timeout", 1, 0);
        break;
      end
    end
    s_valid = 0; s_last = 0;
  endtask

  task automatic frame(input int n, input bit last_end, input int base, input bit rnd);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] d;
      d = rnd ? DW'($urandom) : DW'(base + i);
      if (i < IMG) sent[i] = d;
      beat(d, last_end && (i == n - 1));
    end
  endtask

  task automatic finish_run(input int hold);
    if (cnn_enable) tick();
    s_valid = 1; s_data = $urandom; s_last = $urandom; cnn_done = 0;
    repeat (hold) tick();
    cnn_done = 1;
    tick();
    cnn_done = 0; s_valid = 0; s_last = 0;
  endtask

  task automatic do_reset();
    s_valid = 0; cnn_done = 0; rst_n = 0;
    tick(); tick();
    rst_n = 1;
    tick();
  endtask

  initial begin
    int e0, n0, a0;
    tick(); tick();
    rst_n = 1;
    tick();
    chk("rst_ready", s_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_frames", frames_done, 0);
    chk("rst_word0", img_flat[DW-1:0], 0);

    // full frame of ones
    gap_max = 0;
    n0 = en_cnt;
    for (int i = 0; i < IMG; i++) beat(32'd1, i == IMG - 1);
    chk("fire_enable", cnn_enable, 1);
    chk("fire_ready", s_ready, 0);
    chk("fire_busy", busy, 1);
    for (int i = 0; i < IMG; i++) chk($sformatf("ones_w%0d", i), img_flat[i*DW +: DW], 1);
    cnn_done = 1;
    tick();
    cnn_done = 0;
    chk("wait_enable", cnn_enable, 0);
    chk("wait_busy", busy, 1);
    chk("stale_done_ignored", frames_done, 0);
    finish_run(50);
    chk("frames_after_done", frames_done, 1);
    chk("ready_after_done", s_ready, 1);
    chk("one_enable_pulse", en_cnt - n0, 1);

    // short frame then a valid counting frame
    e0 = err_cnt; n0 = en_cnt;
    frame(10, 1, 0, 0);
    tick();
    chk("short_err", err_cnt - e0, 1);
    chk("short_no_enable", en_cnt - n0, 0);
    frame(IMG, 1, 0, 0);
    for (int i = 0; i < IMG; i++) chk($sformatf("count_w%0d", i), img_flat[i*DW +: DW], i);
    finish_run(3);

    // long frame: 64 beats without last, then 3 dropped beats
    e0 = err_cnt; n0 = en_cnt;
    frame(IMG, 0, 100, 0);
    frame(3, 1, 999, 0);
    tick();
    chk("long_err", err_cnt - e0, 1);
    chk("long_no_enable", en_cnt - n0, 0);
    for (int i = 0; i < IMG; i++) chk($sformatf("long_w%0d", i), img_flat[i*DW +: DW], 100 + i);
    chk("long_ready", s_ready, 1);

    // throttled valid
    gap_max = 3;
    a0 = acc_cnt;
    frame(IMG, 1, 0, 1);
    for (int i = 0; i < IMG; i++) chk($sformatf("gap_w%0d", i), img_flat[i*DW +: DW], sent[i]);
    tick();
    chk("gap_accepts", acc_cnt - a0, IMG);
    finish_run(2);

    // reset mid-frame
    gap_max = 0;
    frame(31, 0, 7, 0);
    e0 = err_cnt;
    do_reset();
    chk("midrst_frames", frames_done, 0);
    chk("midrst_word5", img_flat[5*DW +: DW], 0);
    frame(IMG, 1, 500, 0);
    for (int i = 0; i < IMG; i++) chk($sformatf("rst_w%0d", i), img_flat[i*DW +: DW], 500 + i);
    chk("midrst_no_err", err_cnt - e0, 0);
    chk("midrst_frames_pre", frames_done, 0);
    finish_run(2);
    chk("midrst_frames_post", frames_done, 1);

    // randomized mix of frame shapes, stale done flags and resets
    gap_max = 2;
    for (int t = 0; t < 40; t++) begin
      int kind;
      kind = $urandom_range(0, 3);
      if (kind <= 1) begin
        frame(IMG, 1, 0, 1);
        if ($urandom_range(0, 9) == 0) do_reset();
        else finish_run($urandom_range(0, 4));
      end else if (kind == 2) begin
        frame($urandom_range(1, IMG - 1), 1, 0, 1);
      end else begin
        frame(IMG, 0, 0, 1);
        frame($urandom_range(1, 4), 1, 0, 1);
      end
    end
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 Parameter IMG_SIZE, default 64: number of pixel words per image (8x8).
REQ-002 Parameter DATA_W, default 32: pixel word width in bits.
REQ-003 Parameter CNT_W, default 16: width of the completed-frame counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 s_valid  input  1  upstream pixel beat valid.
REQ-007 s_ready  output  1  loader can accept a pixel beat this cycle.
REQ-008 s_data  input  DATA_W  pixel word.
REQ-009 s_last  input  1  marks the final beat of an image.
REQ-010 img_flat  output  IMG_SIZE*DATA_W  assembled image; word i on bits [DATA_W*i+DATA_W-1 : DATA_W*i], feeds the CNN core's input_img.
REQ-011 cnn_enable  output  1  one-cycle start pulse to the CNN core.
REQ-012 cnn_done  input  1  CNN core completion flag.
REQ-013 frame_err  output  1  one-cycle pulse when a malformed frame is discarded.
REQ-014 busy  output  1  high while in FIRE or WAIT.
REQ-015 frames_done  output  CNT_W  count of images completed by the CNN core.

Function
REQ-016 The FSM SHALL have three states: LOAD, FIRE, WAIT.
REQ-017 In LOAD: s_ready=1; in FIRE and WAIT: s_ready=0.
REQ-018 A beat is accepted only when s_valid=1 and s_ready=1; s_data is then written to word wr_idx, and wr_idx increments by 1.
REQ-019 Accepted beat at wr_idx=IMG_SIZE-1 with s_last=1: next state FIRE, wr_idx returns to 0.
REQ-020 Accepted beat with s_last=1 at wr_idx<IMG_SIZE-1 (short frame): frame_err=1 next cycle, wr_idx returns to 0, state stays LOAD, no cnn_enable.
REQ-021 Accepted beat at wr_idx=IMG_SIZE-1 with s_last=0 (long frame): frame_err=1 next cycle, wr_idx returns to 0, state stays LOAD. All further beats up to and including the next s_last=1 beat are accepted and dropped (no buffer write). Frame reception then resumes at word 0.
REQ-022 img_flat words SHALL be registered. They change only on accepted, non-dropped beats. They hold stable through FIRE and WAIT.
REQ-023 FIRE SHALL last exactly one cycle with cnn_enable=1, then move to WAIT. cnn_enable=0 in every other state.
REQ-024 Latency: last beat accepted on edge N -> cnn_enable high during the cycle after edge N (registered output).
REQ-025 In WAIT, cnn_done=1 sampled on an edge SHALL return the FSM to LOAD and increment frames_done, which wraps from 2^CNT_W-1 to 0.
REQ-026 cnn_done=1 while in FIRE or LOAD SHALL be ignored (stale flag from the prior run).
REQ-027 s_valid with s_ready=0 SHALL NOT alter any state; upstream holds the beat.
REQ-028 busy SHALL be a registered decode of state, high exactly in FIRE and WAIT.

Reset
REQ-029 rst_n=0 SHALL immediately force: state LOAD, wr_idx 0, drop mode off, all img_flat words 0, cnn_enable 0, frame_err 0, frames_done 0, busy 0. s_ready=1 once rst_n=1.
REQ-030 Reset asserted mid-frame or in WAIT SHALL discard the partial frame or run without issuing frame_err or cnn_enable.

Verification
REQ-031 Stream 64 beats of 32'd1, s_valid held high, s_last on beat 63 -> every img_flat word = 1; cnn_enable high for exactly one cycle, one cycle after the last accept; s_ready=0; busy=1.
REQ-032 In WAIT, hold cnn_done=0 for 50 cycles, then pulse it -> s_ready stays 0 throughout; on the pulse, frames_done 0->1 and s_ready=1 on the next cycle.
REQ-033 Send 10 beats with s_last on beat 9 -> frame_err pulses once, no cnn_enable. A following valid 64-beat frame of values 0..63 -> word i = i.
REQ-034 Send 64 beats without s_last, then 3 beats with s_last on the third -> one frame_err pulse, img_flat unchanged, no cnn_enable.
REQ-035 Toggle s_valid randomly across a 64-beat frame -> identical img_flat; exactly 64 accepts.
REQ-036 Assert rst_n=0 after beat 30, then send a full frame -> no frame_err; img_flat holds only the new frame; frames_done=0 until cnn_done.
